// File: rtl/vending_pkg.sv
// Shared state encoding and helpers for the vending controller.
package vending_pkg;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_CREDIT   = 2'd1;
   localparam logic [1:0] ST_DISPENSE = 2'd2;
   localparam logic [1:0] ST_CHANGE   = 2'd3;

   localparam int MAX_PROD = 16;
   localparam int MAX_W    = 32;

   function automatic logic is_onehot(input logic [MAX_PROD-1:0] v);
      return (v != '0) && ((v & (v - 16'd1)) == '0);
   endfunction

   // Callers zero-extend their price table to the widest supported shape.
   function automatic logic [MAX_W-1:0] price_slice(input logic [MAX_PROD*MAX_W-1:0] tbl,
                                                    input int idx, input int w);
      logic [MAX_PROD*MAX_W-1:0] sh;
      sh = tbl >> (idx * w);
      return sh[MAX_W-1:0] & ((MAX_W'(1) << w) - MAX_W'(1));
   endfunction

endpackage

// File: rtl/vending_sel_decode.sv
// Product button decode: one-hot check, selected index and its price.
module vending_sel_decode
   import vending_pkg::*;
#(
   parameter int N_PROD   = 2,
   parameter int CREDIT_W = 8,
   localparam int IDX_W   = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
   input  logic [N_PROD-1:0]          sel_btn,
   input  logic [N_PROD*CREDIT_W-1:0] prices,
   output logic                       valid,
   output logic [IDX_W-1:0]           index,
   output logic [CREDIT_W-1:0]        price
);

   logic [MAX_PROD*MAX_W-1:0] prices_ext;
   logic [MAX_PROD-1:0]       sel_ext;

   always_comb begin
      prices_ext = '0;
      prices_ext[N_PROD*CREDIT_W-1:0] = prices;
      sel_ext = '0;
      sel_ext[N_PROD-1:0] = sel_btn;
      index = '0;
      for (int i = 0; i < N_PROD; i++) begin
         if (sel_btn[i]) index = IDX_W'(i);
      end
      price = CREDIT_W'(price_slice(prices_ext, int'(index), CREDIT_W));
      valid = is_onehot(sel_ext) && (price != '0);
   end

endmodule

// File: rtl/vending_fsm.sv
// Vending controller: coin credit, priced selection, timed dispense pulse and
// change handshake toward the hopper.
//
// state       | meaning
// ST_IDLE     | no credit held
// ST_CREDIT   | credit > 0, waiting for selection, coin or cancel
// ST_DISPENSE | dispense line held high for DISPENSE_CYCLES cycles
// ST_CHANGE   | change_valid high until change_ack
module vending_fsm
   import vending_pkg::*;
#(
   parameter int N_PROD          = 2,
   parameter int CREDIT_W        = 8,
   parameter int MAX_CREDIT      = 200,
   parameter int DISPENSE_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       coin_valid,
   input  logic [CREDIT_W-1:0]        coin_value,
   input  logic [N_PROD-1:0]          sel_btn,
   input  logic                       cancel,
   input  logic [N_PROD*CREDIT_W-1:0] prices,
   output logic [N_PROD-1:0]          dispense,
   output logic                       change_valid,
   output logic [CREDIT_W-1:0]        change_value,
   input  logic                       change_ack,
   output logic [CREDIT_W-1:0]        credit,
   output logic                       coin_reject,
   output logic                       sel_error,
   output logic                       busy
);

   localparam int IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
   localparam int CNT_W = $clog2(DISPENSE_CYCLES + 1);

   logic [1:0]          state;
   logic [CNT_W-1:0]    disp_cnt;
   logic                sel_prev;
   logic                sel_valid;
   logic [IDX_W-1:0]    sel_idx;
   logic [CREDIT_W-1:0] sel_price;
   logic [N_PROD-1:0]   sel_onehot;
   logic [CREDIT_W:0]   coin_sum;
   logic                sel_any, sel_edge, cancel_hit, coin_ok;

   vending_sel_decode #(.N_PROD(N_PROD), .CREDIT_W(CREDIT_W)) u_decode (
      .sel_btn (sel_btn),
      .prices  (prices),
      .valid   (sel_valid),
      .index   (sel_idx),
      .price   (sel_price)
   );

   // A selection is only evaluated on the press, so a held button cannot
   // repeat sel_error or silently buy once enough coins arrive.
   assign sel_any    = |sel_btn;
   assign sel_edge   = sel_any & ~sel_prev;
   assign sel_onehot = N_PROD'(1) << sel_idx;
   assign coin_sum   = {1'b0, credit} + {1'b0, coin_value};
   assign cancel_hit = cancel && (state == ST_CREDIT);
   assign coin_ok    = !cancel_hit && !sel_edge && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         credit       <= '0;
         dispense     <= '0;
         change_valid <= 1'b0;
         change_value <= '0;
         coin_reject  <= 1'b0;
         sel_error    <= 1'b0;
         busy         <= 1'b0;
         disp_cnt     <= '0;
         sel_prev     <= 1'b0;
      end else begin
         coin_reject <= 1'b0;
         sel_error   <= 1'b0;
         sel_prev    <= sel_any;
         case (state)
            ST_IDLE, ST_CREDIT: begin
               if (cancel_hit) begin
                  change_value <= credit;
                  change_valid <= 1'b1;
                  credit       <= '0;
                  busy         <= 1'b1;
                  state        <= ST_CHANGE;
               end else if (sel_edge) begin
                  if (sel_valid && (credit >= sel_price)) begin
                     credit   <= credit - sel_price;
                     dispense <= sel_onehot;
                     disp_cnt <= CNT_W'(DISPENSE_CYCLES);
                     busy     <= 1'b1;
                     state    <= ST_DISPENSE;
                  end else begin
                     sel_error <= 1'b1;
                  end
               end else if (coin_valid && coin_ok) begin
                  credit <= coin_sum[CREDIT_W-1:0];
                  if (coin_sum != '0) state <= ST_CREDIT;
               end
               if (coin_valid && !coin_ok) coin_reject <= 1'b1;
            end
            ST_DISPENSE: begin
               if (coin_valid) coin_reject <= 1'b1;
               disp_cnt <= disp_cnt - CNT_W'(1);
               if (disp_cnt == CNT_W'(1)) begin
                  dispense <= '0;
                  if (credit != '0) begin
                     change_value <= credit;
                     change_valid <= 1'b1;
                     credit       <= '0;
                     state        <= ST_CHANGE;
                  end else begin
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
            end
            ST_CHANGE: begin
               if (coin_valid) coin_reject <= 1'b1;
               if (change_ack) begin
                  change_valid <= 1'b0;
                  change_value <= '0;
                  busy         <= 1'b0;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vending_fsm.sv
// Directed and randomized bench for vending_fsm against a cycle-level
// behavioural model of the vending rules.
module tb_vending_fsm;

   localparam int DC   = 4;
   localparam int MAXC = 200;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       coin_valid;
   logic [7:0] coin_value;
   logic [1:0] sel_btn;
   logic       cancel;
   logic [15:0] prices;
   logic [1:0] dispense;
   logic       change_valid;
   logic [7:0] change_value;
   logic       change_ack;
   logic [7:0] credit;
   logic       coin_reject;
   logic       sel_error;
   logic       busy;

   int errors = 0;
   int checks = 0;

   // model: phase 0 = waiting for coins/selection, 1 = dispensing, 2 = paying change
   int m_credit, m_phase, m_left, m_didx, m_chg;
   bit m_rej, m_serr, m_prev_any;

   vending_fsm #(.N_PROD(2), .CREDIT_W(8), .MAX_CREDIT(MAXC), .DISPENSE_CYCLES(DC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .coin_valid   (coin_valid),
      .coin_value   (coin_value),
      .sel_btn      (sel_btn),
      .cancel       (cancel),
      .prices       (prices),
      .dispense     (dispense),
      .change_valid (change_valid),
      .change_value (change_value),
      .change_ack   (change_ack),
      .credit       (credit),
      .coin_reject  (coin_reject),
      .sel_error    (sel_error),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_credit = 0; m_phase = 0; m_left = 0; m_didx = 0; m_chg = 0;
      m_rej = 0; m_serr = 0; m_prev_any = 0;
   endtask

   function automatic int price_of(input int i);
      return (i == 0) ? int'(prices[7:0]) : int'(prices[15:8]);
   endfunction

   task automatic model_edge(input bit cv, input int cval, input int sb, input bit cn, input bit ack);
      bit pressed, acted;
      int idx;
      pressed = (sb != 0) && !m_prev_any;
      m_prev_any = (sb != 0);
      m_rej = 0;
      m_serr = 0;
      acted = 0;
      if (m_phase == 0) begin
         if (cn && m_credit > 0) begin
            m_chg = m_credit; m_credit = 0; m_phase = 2; acted = 1;
         end else if (pressed) begin
            acted = 1;
            idx = (sb == 2) ? 1 : 0;
            if ($countones(sb) == 1 && price_of(idx) != 0 && m_credit >= price_of(idx)) begin
               m_credit -= price_of(idx); m_phase = 1; m_left = DC; m_didx = idx;
            end else m_serr = 1;
         end
         if (cv) begin
            if (acted || m_credit + cval > MAXC) m_rej = 1;
            else m_credit += cval;
         end
      end else if (m_phase == 1) begin
         if (cv) m_rej = 1;
         m_left--;
         if (m_left == 0) begin
            if (m_credit > 0) begin m_chg = m_credit; m_credit = 0; m_phase = 2; end
            else m_phase = 0;
         end
      end else begin
         if (cv) m_rej = 1;
         if (ack) begin m_chg = 0; m_phase = 0; end
      end
   endtask

   task automatic check_all();
      chk("credit", credit, m_credit);
      chk("dispense", dispense, (m_phase == 1) ? (1 << m_didx) : 0);
      chk("change_valid", change_valid, m_phase == 2);
      chk("change_value", change_value, m_chg);
      chk("coin_reject", coin_reject, m_rej);
      chk("sel_error", sel_error, m_serr);
      chk("busy", busy, m_phase != 0);
   endtask

   task automatic step(input bit cv, input int cval, input int sb, input bit cn, input bit ack);
      coin_valid = cv;
      coin_value = 8'(cval);
      sel_btn    = 2'(sb);
      cancel     = cn;
      change_ack = ack;
      @(posedge clk);
      model_edge(cv, cval, sb, cn, ack);
      #1;
      check_all();
      coin_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   initial begin
      int coins[6] = '{0, 5, 10, 20, 50, 100};
      int plist[5] = '{0, 30, 50, 80, 120};
      rst_n = 1'b0; coin_valid = 0; coin_value = 0; sel_btn = 0; cancel = 0; change_ack = 0;
      prices = {8'd80, 8'd50};
      model_reset();
      #2;
      check_all();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // coffee with exact credit, no change
      step(1, 50, 0, 0, 0);
      chk("t1_credit", credit, 50);
      step(0, 0, 1, 0, 0);
      chk("t1_disp", dispense, 2'b01);
      idle(6);

      // soup with change 20
      step(1, 50, 0, 0, 0);
      step(1, 50, 0, 0, 0);
      step(0, 0, 2, 0, 0);
      idle(4);
      chk("t2_chg", change_value, 20);
      idle(2);
      step(0, 0, 0, 0, 1);
      idle(1);

      // over-limit coin, then coin during dispense
      step(1, 100, 0, 0, 0);
      step(1, 50, 0, 0, 0);
      step(1, 20, 0, 0, 0);
      step(1, 20, 0, 0, 0);
      step(1, 20, 0, 0, 0);
      chk("t3_credit", credit, 190);
      step(0, 0, 1, 0, 0);
      step(1, 10, 0, 0, 0);
      idle(4);
      step(0, 0, 0, 0, 1);

      // multi-hot and insufficient credit, held button
      step(1, 100, 0, 0, 0);
      step(0, 0, 3, 0, 0);
      idle(1);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1);
      step(1, 20, 0, 0, 0);
      step(1, 10, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("t4_credit", credit, 30);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1);

      // same-cycle cancel+coin, then sel+coin
      step(1, 40, 0, 0, 0);
      step(1, 10, 0, 1, 0);
      chk("t5_chg", change_value, 40);
      step(0, 0, 0, 0, 1);
      step(1, 50, 0, 0, 0);
      step(1, 10, 1, 0, 0);
      idle(5);

      // zero coin in idle, then reset in second dispense cycle
      step(1, 0, 0, 0, 0);
      step(1, 60, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_disp", dispense, 0);
      chk("rst_credit", credit, 0);
      chk("rst_busy", busy, 0);
      chk("rst_chg", change_valid, 0);
      #2;
      rst_n = 1'b1;
      idle(6);

      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 25) prices = {8'(plist[$urandom_range(4)]), 8'(plist[$urandom_range(4)])};
         step(($urandom_range(9) < 4), coins[$urandom_range(5)],
              ($urandom_range(9) < 6) ? 0 : int'($urandom_range(3)),
              ($urandom_range(9) == 0), ($urandom_range(9) < 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vending_fsm.md
Name: vending_fsm

Overview:
Parametrised, clocked vending controller that generalises the combinational coffee/soup selector. It supports N_PROD products with per-product prices and accumulates coin credit. It dispenses the selected product for a fixed pulse width and returns change through a valid/ack handshake. It sits between the coin-acceptor/button front end and the dispenser and change-hopper drivers.

Parameters:
N_PROD, 2, number of products (index 0 = coffee, 1 = soup); range 1..16
CREDIT_W, 8, width of coin, price, credit and change values
MAX_CREDIT, 200, highest credit the machine will hold; must be less than 2**CREDIT_W
DISPENSE_CYCLES, 4, number of cycles a dispense output stays high; must be at least 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
coin_valid  in  1  single-cycle strobe: a coin has been inserted
coin_value  in  CREDIT_W  value of the coin; sampled when coin_valid=1
sel_btn  in  N_PROD  product buttons; level-sensitive; bit i selects product i
cancel  in  1  refund request; level-sensitive
prices  in  N_PROD*CREDIT_W  packed price table; product i uses bits [i*CREDIT_W +: CREDIT_W]; price 0 means the product is disabled
dispense  out  N_PROD  one-hot output, held high for DISPENSE_CYCLES cycles
change_valid  out  1  change is pending
change_value  out  CREDIT_W  amount of change; stable while change_valid=1
change_ack  in  1  hopper has paid out the change
credit  out  CREDIT_W  current credit, registered
coin_reject  out  1  one-cycle pulse: the coin was not accepted
sel_error  out  1  one-cycle pulse: the selection was invalid or credit was insufficient
busy  out  1  high in DISPENSE and CHANGE

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; credit=0; dispense=0; change_valid=0; change_value=0; coin_reject=0; sel_error=0; busy=0; dispense counter=0.
- States: IDLE (credit=0), CREDIT (credit>0), DISPENSE, CHANGE. All outputs are registered.
- Event priority in IDLE/CREDIT, per cycle: cancel > selection > coin.
- Coin: accepted only when no higher-priority event is acted on in the same cycle and credit+coin_value<=MAX_CREDIT.
  - Accepted: credit increases by coin_value, visible on the next cycle. IDLE moves to CREDIT.
  - Otherwise: coin_reject pulses on the next cycle and credit is unchanged.
  - coin_value=0 with coin_valid=1: coin is accepted as a no-op; no reject pulse.
  - Sum is computed CREDIT_W+1 bits wide, so it cannot wrap.
- Selection: valid only when sel_btn is exactly one-hot and the selected price is nonzero.
  - Valid and credit>=price: credit becomes credit-price; go to DISPENSE.
  - Zero-hot: no action.
  - Multi-hot, disabled product, or insufficient credit: sel_error pulses for one cycle; state is unchanged.
  - A button held for many cycles re-triggers sel_error at most once per press (edge-detect on sel_btn != 0).
- Cancel: in CREDIT, change_value=credit, credit=0, go to CHANGE. In IDLE, ignored.
- DISPENSE: dispense[i]=1 for exactly DISPENSE_CYCLES cycles, starting the cycle after acceptance.
  - After that: go to CHANGE if credit>0 (change_value=credit, credit=0), else go to IDLE.
  - Coins are rejected; buttons and cancel are ignored.
- CHANGE: change_valid=1 and change_value is held until change_ack=1 is sampled. Then change_valid=0, change_value=0, go to IDLE.
  - Coins are rejected; buttons and cancel are ignored.
  - change_ack outside CHANGE is ignored.
- busy=1 exactly in DISPENSE and CHANGE.
- prices is sampled only in the cycle a selection is evaluated; changes at other times have no effect on a dispense already in progress.
- Reset mid-dispense or mid-change: outputs drop immediately (asynchronous); any credit is lost by design.

Decomposition:
- Package vending_pkg: state enum (IDLE, CREDIT, DISPENSE, CHANGE), the one-hot-check function, and the price-slice helper function.
- Sub-module vending_sel_decode: combinational. Inputs: sel_btn, prices. Outputs: valid, index, price. Keeps the FSM free of the N_PROD mux.

Test Plan:
1. Defaults (N_PROD=2, prices={soup=80, coffee=50}): coin 50, then sel_btn=01 -> credit=50, then 0; dispense=01 for 4 cycles; returns to IDLE; change_valid never asserts.
2. Coins 50+50, then sel_btn=10 (soup=80) -> dispense=10 for 4 cycles; then change_valid=1 with change_value=20 held until change_ack; then IDLE with credit=0.
3. Credit 190, then coin 20 (MAX_CREDIT=200) -> coin_reject pulses once; credit stays 190. A coin inserted during DISPENSE is also rejected.
4. sel_btn=11 with credit 100 -> sel_error pulses once and no dispense occurs. Credit 30 with sel_btn=01 (price 50) -> sel_error pulses; credit stays 30.
5. Same-cycle cancel+coin with credit 40 -> coin_reject pulses; change_value=40; CHANGE entered. Same-cycle sel+coin -> coin rejected; dispense proceeds.
6. rst_n=0 in the second cycle of DISPENSE -> dispense=0, credit=0, state=IDLE immediately; no change is issued after release.
